// File: rtl/gate_unit_pipe.sv
// Eight-op bitwise unit, one-cycle registered result behind valid/ready; in_ready = !out_valid || out_ready.
// Optional GATE_UNIT_ACC_EN: an accepted beat with ACC=1 uses the previous result in place of B.
module gate_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  input  logic             ACC,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Z,
  output logic [CNT_W-1:0] txn_count
);

  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] result;
  logic             accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign Z        = (Y == '0);

`ifdef GATE_UNIT_ACC_EN
  // Chaining feeds the held result back as the second operand.
  assign b_sel = ACC ? Y : B;
`else
  logic unused_acc;
  assign unused_acc = ACC;
  assign b_sel      = B;
`endif

  always_comb begin
    result = '0;
    case (OP)
      3'd0:    result = A & b_sel;
      3'd1:    result = A | b_sel;
      3'd2:    result = A ^ b_sel;
      3'd3:    result = ~(A & b_sel);
      3'd4:    result = ~(A | b_sel);
      3'd5:    result = ~(A ^ b_sel);
      3'd6:    result = ~A;
      default: result = A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Y         <= '0;
      out_valid <= 1'b0;
      txn_count <= '0;
    end else if (accept) begin
      Y         <= result;
      out_valid <= 1'b1;
      txn_count <= txn_count + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
